// File: rtl/mem_a_row_loader.sv
// mem_a_row_loader: packs a valid/ready element stream into A-memory rows and writes one row per cluster.
// The optional running XOR checksum is built only when MEM_A_LOADER_CHECKSUM_EN is defined.
module mem_a_row_loader #(
  parameter int number_of_clusters = 1,
  parameter int number_of_equations_per_cluster = 9,
  parameter int element_width = 64,
  parameter int address_width = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic [element_width-1:0] in_data,
  output logic in_ready,
  output logic wr_en,
  output logic [address_width-1:0] wr_address,
  output logic [element_width*(3*number_of_equations_per_cluster-2)-1:0] wr_data,
  output logic busy,
  output logic done,
  output logic [element_width-1:0] checksum
);
  localparam int E = 3*number_of_equations_per_cluster-2;
  localparam int RB = element_width*E;
  localparam int EW = E > 1 ? $clog2(E) : 1;
  localparam int RW = number_of_clusters > 1 ? $clog2(number_of_clusters) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t state;
  logic [EW-1:0] ecnt;
  logic [RW-1:0] rcnt;
  logic [RB-1:0] row, row_next;
  logic accept, last_elem, last_row;
  assign accept = in_valid & in_ready;
  assign last_elem = ecnt == EW'(E-1);
  assign last_row = rcnt == RW'(number_of_clusters-1);
  // Row contents including the element being accepted this cycle.
  always_comb begin
    row_next = row;
    row_next[ecnt*element_width +: element_width] = in_data;
  end
  // Load/write sequencing with registered handshake and write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ecnt <= '0;
      rcnt <= '0;
      row <= '0;
      in_ready <= 1'b0;
      wr_en <= 1'b0;
      wr_address <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
          in_ready <= 1'b1;
          ecnt <= '0;
          rcnt <= '0;
        end
        LOAD: if (accept) begin
          row <= row_next;
          ecnt <= last_elem ? '0 : ecnt + 1'b1;
          if (last_elem) begin
            state <= WRITE;
            in_ready <= 1'b0;
            wr_en <= 1'b1;
            wr_address <= address_width'(rcnt);
            wr_data <= row_next;
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          if (last_row) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= LOAD;
            in_ready <= 1'b1;
            rcnt <= rcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end
`ifdef MEM_A_LOADER_CHECKSUM_EN
  logic [element_width-1:0] sum;
  // Running XOR of accepted elements, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else if (state == IDLE && start) sum <= '0;
    else if (accept) sum <= sum ^ in_data;
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_mem_a_row_loader.sv
// tb_mem_a_row_loader: randomized self-checking bench against a row-packing reference model.
module tb_mem_a_row_loader;
  localparam int W = 64;
  localparam int E = 25;
  localparam int RB = W*E;
  logic clk = 0, rst = 1, in_valid = 0, start_a = 0, start_b = 0, start_c = 0;
  logic [W-1:0] in_data = '0;
  logic ready_a, wr_en_a, busy_a, done_a, ready_b, wr_en_b, busy_b, done_b, ready_c, wr_en_c, busy_c, done_c;
  logic [19:0] addr_a, addr_b, addr_c;
  logic [RB-1:0] data_a, data_b;
  logic [W-1:0] data_c, sum_a, sum_b, sum_c;
  int tests = 0, fails = 0, viol = 0;
  logic [W-1:0] elems[$];
  int qa_addr[$], qb_addr[$], qc_addr[$];
  logic [RB-1:0] qa_data[$], qb_data[$];
  logic [W-1:0] qc_data[$];

  mem_a_row_loader #(.number_of_clusters(1), .number_of_equations_per_cluster(9)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data), .in_ready(ready_a),
    .wr_en(wr_en_a), .wr_address(addr_a), .wr_data(data_a), .busy(busy_a), .done(done_a), .checksum(sum_a));
  mem_a_row_loader #(.number_of_clusters(3), .number_of_equations_per_cluster(9)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data), .in_ready(ready_b),
    .wr_en(wr_en_b), .wr_address(addr_b), .wr_data(data_b), .busy(busy_b), .done(done_b), .checksum(sum_b));
  mem_a_row_loader #(.number_of_clusters(2), .number_of_equations_per_cluster(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .in_data(in_data), .in_ready(ready_c),
    .wr_en(wr_en_c), .wr_address(addr_c), .wr_data(data_c), .busy(busy_c), .done(done_c), .checksum(sum_c));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en_a) begin qa_addr.push_back(int'(addr_a)); qa_data.push_back(data_a); end
    if (wr_en_b) begin qb_addr.push_back(int'(addr_b)); qb_data.push_back(data_b); end
    if (wr_en_c) begin qc_addr.push_back(int'(addr_c)); qc_data.push_back(data_c); end
    if ((wr_en_a && ready_a) || (wr_en_b && ready_b) || (wr_en_c && ready_c)) viol++;
  end

  function automatic logic rdy(input int d);
    return d == 0 ? ready_a : d == 1 ? ready_b : ready_c;
  endfunction

  function automatic logic dn(input int d);
    return d == 0 ? done_a : d == 1 ? done_b : done_c;
  endfunction

  function automatic logic [RB-1:0] exp_row(input int base);
    logic [RB-1:0] r = '0;
    for (int k = 0; k < E; k++) r[k*W +: W] = elems[base+k];
    return r;
  endfunction

  task automatic pulse(input int d);
    @(negedge clk);
    start_a = d == 0; start_b = d == 1; start_c = d == 2;
    @(negedge clk);
    start_a = 0; start_b = 0; start_c = 0;
  endtask

  task automatic feed(input int d, input int lo, input int hi, input bit gaps);
    int i = lo, t = 0;
    while (i < hi && t < 5000) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = in_valid ? elems[i] : {$urandom, $urandom};
      if (in_valid && rdy(d)) i++;
      t++;
    end
    @(negedge clk);
    in_valid = 0;
    in_data = {$urandom, $urandom};
    tests++; if (i < hi) begin fails++; $display("FAIL feed_timeout: accepted %0d want %0d", i, hi); end
  endtask

  task automatic wait_done(input int d);
    bit seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = dn(d);
    end
    tests++; if (!seen) begin fails++; $display("FAIL done_timeout: dut %0d no done pulse", d); end
  endtask

  task automatic rand_elems(input int n);
    elems.delete();
    for (int i = 0; i < n; i++) elems.push_back({$urandom, $urandom});
  endtask

  task automatic test_reset;
    #12;
    tests++; if ({ready_a, wr_en_a, busy_a, done_a, ready_b, wr_en_b, busy_b, done_b, ready_c, wr_en_c, busy_c, done_c} !== '0) begin
      fails++; $display("FAIL reset_ctrl: got nonzero control outputs want 0"); end
    tests++; if ({addr_a, addr_b, addr_c, data_a, data_b, data_c, sum_a, sum_b, sum_c} !== '0) begin
      fails++; $display("FAIL reset_data: got nonzero data outputs want 0"); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single;
    elems.delete();
    for (int i = 1; i <= E; i++) elems.push_back(W'(i));
    pulse(0);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy_a); end
    feed(0, 0, E, 0);
    tests++; if (wr_en_a !== 1'b1) begin fails++; $display("FAIL single_wr_en: got %b want 1", wr_en_a); end
    tests++; if (addr_a !== 20'd0) begin fails++; $display("FAIL single_addr: got %0d want 0", addr_a); end
    tests++; if (data_a[63:0] !== 64'h1 || data_a[1599:1536] !== 64'h19) begin
      fails++; $display("FAIL single_ends: got %h/%h want 1/19", data_a[63:0], data_a[1599:1536]); end
    tests++; if (data_a !== exp_row(0)) begin fails++; $display("FAIL single_row: got %h want %h", data_a, exp_row(0)); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL single_early_done: got %b want 0", done_a); end
    @(negedge clk);
    tests++; if ({wr_en_a, done_a, busy_a} !== 3'b010) begin fails++; $display("FAIL single_done: got wr/done/busy %b want 010", {wr_en_a, done_a, busy_a}); end
    @(negedge clk);
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL single_done_pulse: got %b want 0", done_a); end
  endtask

  task automatic test_checksum;
    logic [W-1:0] x = '0;
    logic [W-1:0] want;
    elems.delete();
    for (int i = 1; i <= E; i++) elems.push_back(W'(i));
    for (int i = 0; i < E; i++) x ^= elems[i];
    pulse(0);
    feed(0, 0, E, 1);
    wait_done(0);
    @(negedge clk);
`ifdef MEM_A_LOADER_CHECKSUM_EN
    want = x;
`else
    want = '0;
`endif
    tests++; if (sum_a !== want) begin fails++; $display("FAIL checksum_final: got %h want %h", sum_a, want); end
    rand_elems(E);
    pulse(0);
    tests++; if (sum_a !== '0) begin fails++; $display("FAIL checksum_clear: got %h want 0", sum_a); end
    feed(0, 0, E, 1);
    wait_done(0);
    @(negedge clk);
  endtask

  task automatic test_idle_ignore;
    int n0 = qa_addr.size();
    bit bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1; in_data = {$urandom, $urandom};
      if (ready_a !== 1'b0 || busy_a !== 1'b0) bad = 1;
    end
    @(negedge clk);
    in_valid = 0;
    tests++; if (bad || ready_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL idle_ready: got ready %b busy %b want 0 0", ready_a, busy_a); end
    rand_elems(E);
    pulse(0);
    feed(0, 0, 12, 1);
    pulse(0);
    tests++; if (busy_a !== 1'b1 || ready_a !== 1'b1) begin fails++; $display("FAIL midload_start: got busy %b ready %b want 1 1", busy_a, ready_a); end
    feed(0, 12, E, 1);
    wait_done(0);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    @(negedge clk);
    tests++; if (busy_a !== 1'b0 || ready_a !== 1'b0) begin fails++; $display("FAIL done_start: got busy %b ready %b want 0 0", busy_a, ready_a); end
    tests++; if (qa_addr.size() != n0 + 1) begin fails++; $display("FAIL idle_writes: got %0d want %0d", qa_addr.size(), n0 + 1); end
    tests++; if (qa_data[$] !== exp_row(0) || qa_addr[$] != 0) begin fails++; $display("FAIL midload_row: got %h want %h", qa_data[$], exp_row(0)); end
  endtask

  task automatic test_reset_midload;
    rand_elems(E);
    qa_addr.delete(); qa_data.delete();
    pulse(0);
    feed(0, 0, 10, 0);
    #2 rst = 1;
    #1;
    tests++; if ({ready_a, wr_en_a, busy_a, done_a} !== 4'b0) begin fails++; $display("FAIL rst_ctrl: got %b want 0000", {ready_a, wr_en_a, busy_a, done_a}); end
    tests++; if ({addr_a, data_a, sum_a} !== '0) begin fails++; $display("FAIL rst_data: got nonzero want 0"); end
    @(negedge clk);
    rst = 0;
    tests++; if (qa_addr.size() != 0) begin fails++; $display("FAIL rst_nowrite: got %0d writes want 0", qa_addr.size()); end
    rand_elems(E);
    pulse(0);
    feed(0, 0, E, 1);
    wait_done(0);
    @(negedge clk);
    tests++; if (qa_addr.size() != 1) begin fails++; $display("FAIL rst_reload_count: got %0d want 1", qa_addr.size()); end
    else begin
      tests++; if (qa_addr[0] != 0 || qa_data[0] !== exp_row(0)) begin fails++; $display("FAIL rst_reload_row: got %h want %h", qa_data[0], exp_row(0)); end
    end
  endtask

  task automatic test_multi;
    rand_elems(3*E);
    qb_addr.delete(); qb_data.delete();
    viol = 0;
    pulse(1);
    feed(1, 0, 3*E, 1);
    wait_done(1);
    @(negedge clk);
    tests++; if (qb_addr.size() != 3) begin fails++; $display("FAIL multi_count: got %0d want 3", qb_addr.size()); end
    else for (int r = 0; r < 3; r++) begin
      tests++; if (qb_addr[r] != r) begin fails++; $display("FAIL multi_addr: got %0d want %0d", qb_addr[r], r); end
      tests++; if (qb_data[r] !== exp_row(r*E)) begin fails++; $display("FAIL multi_row%0d: got %h want %h", r, qb_data[r], exp_row(r*E)); end
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL write_ready: got %0d cycles with in_ready want 0", viol); end
  endtask

  task automatic test_n1;
    rand_elems(2);
    qc_addr.delete(); qc_data.delete();
    pulse(2);
    feed(2, 0, 2, 1);
    wait_done(2);
    @(negedge clk);
    tests++; if (qc_addr.size() != 2) begin fails++; $display("FAIL n1_count: got %0d want 2", qc_addr.size()); end
    else for (int r = 0; r < 2; r++) begin
      tests++; if (qc_addr[r] != r || qc_data[r] !== elems[r]) begin fails++; $display("FAIL n1_row%0d: got %0d/%h want %0d/%h", r, qc_addr[r], qc_data[r], r, elems[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_checksum();
    test_idle_ignore();
    test_reset_midload();
    test_multi();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
